uart_fifo_port: RTL

UART_FIFO_PORT -- requirements
Module: uart_fifo_port

---
 rtl/uart_fifo_port.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_port.sv
// UART with TX and RX FIFOs, 16x oversampling, configurable frame format.
// RX FIFO is first-word fall-through; error flags travel with each received byte.
module uart_fifo_port #(
  parameter int unsigned OVS_DIV    = 27,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 uart_port_DI,
  output logic                 uart_port_DO,
  input  logic [DATA_BITS-1:0] tx_DI,
  input  logic                 tx_write,
  output logic                 tx_full,
  output logic                 send_done,
  output logic [DATA_BITS-1:0] uart_DO,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 read_valid,
  input  logic                 rx_read,
  output logic                 rx_overrun
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned RW     = DATA_BITS + 2;
  localparam logic        ParOn  = (PARITY != 0);
  localparam logic        ParOdd = (PARITY == 1);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Oversampling tick
  logic [15:0] div_q;
  logic        tick;

  assign tick = (div_q == 16'(OVS_DIV - 1));

  always_ff @(posedge clk) begin
    if (clear || tick) div_q <= '0;
    else               div_q <= div_q + 16'd1;
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wptr_q, tx_rptr_q;
  logic                 tx_empty, tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                    (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign tx_push  = tx_write && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (clear) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= tx_DI;
  end

  // TX FSM
  state_e               tx_state_q, tx_state_d;
  logic [3:0]           tx_sub_q, tx_sub_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_do_q, tx_do_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sub_d   = tx_sub_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      StIdle: begin
        if (tick && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_par_d   = ^tx_head ^ ParOdd;
          tx_sub_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            tx_bit_d   = '0;
            tx_state_d = StData;
          end
        end
      end
      StData: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            tx_shift_d = tx_shift_q >> 1;
            if (tx_bit_q == 3'(DATA_BITS - 1)) begin
              tx_bit_d   = '0;
              tx_state_d = ParOn ? StParity : StStop;
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
            end
          end
        end
      end
      StParity: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            tx_bit_d   = '0;
            tx_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          tx_sub_d = tx_sub_q + 4'd1;
          if (tx_sub_q == 4'd15) begin
            if (tx_bit_q == 3'(STOP_BITS - 1)) begin
              tx_bit_d = '0;
              // Chain straight into the next frame when more data is queued.
              if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_par_d   = ^tx_head ^ ParOdd;
                tx_state_d = StStart;
              end else begin
                tx_state_d = StIdle;
              end
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
            end
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase

    case (tx_state_d)
      StStart:  tx_do_d = 1'b0;
      StData:   tx_do_d = tx_shift_d[0];
      StParity: tx_do_d = tx_par_d;
      default:  tx_do_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      tx_state_q <= StIdle;
      tx_sub_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_do_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sub_q   <= tx_sub_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_do_q    <= tx_do_d;
    end
  end

  assign uart_port_DO = tx_do_q;
  assign send_done    = tx_empty && (tx_state_q == StIdle);

  // RX synchroniser and FSM
  logic rx_sync1_q, rx_sync2_q, rx_s;

  always_ff @(posedge clk) begin
    if (clear) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
    end else begin
      rx_sync1_q <= uart_port_DI;
      rx_sync2_q <= rx_sync1_q;
    end
  end

  assign rx_s = rx_sync2_q;

  state_e               rx_state_q, rx_state_d;
  logic [3:0]           rx_sub_q, rx_sub_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_push;
  logic [RW-1:0]        rx_push_word;

  assign rx_push_word = {~rx_s, rx_perr_q, rx_shift_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sub_d   = rx_sub_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (tick && !rx_s) begin
          rx_sub_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          rx_sub_d = rx_sub_q + 4'd1;
          // Mid start bit: a line back high means it was a glitch.
          if (rx_sub_q == 4'd7) begin
            rx_sub_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s ? StIdle : StData;
          end
        end
      end
      StData: begin
        if (tick) begin
          rx_sub_d = rx_sub_q + 4'd1;
          if (rx_sub_q == 4'd15) begin
            rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == 3'(DATA_BITS - 1)) begin
              rx_bit_d   = '0;
              rx_state_d = ParOn ? StParity : StStop;
            end else begin
              rx_bit_d = rx_bit_q + 3'd1;
            end
          end
        end
      end
      StParity: begin
        if (tick) begin
          rx_sub_d = rx_sub_q + 4'd1;
          if (rx_sub_q == 4'd15) begin
            rx_perr_d  = ^rx_shift_q ^ rx_s ^ ParOdd;
            rx_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          rx_sub_d = rx_sub_q + 4'd1;
          if (rx_sub_q == 4'd15) begin
            rx_push    = 1'b1;
            rx_state_d = StIdle;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rx_state_q <= StIdle;
      rx_sub_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sub_q   <= rx_sub_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // RX FIFO
  logic [RW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]   rx_wptr_q, rx_rptr_q;
  logic          rx_empty, rx_full, rx_pop, rx_wr;
  logic          rx_overrun_q;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                    (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign rx_pop   = rx_read && !rx_empty;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (clear) begin
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_wr)  rx_wptr_q <= rx_wptr_q + PtrOne;
      if (rx_pop) rx_rptr_q <= rx_rptr_q + PtrOne;
      if (rx_push && rx_full && !rx_pop) rx_overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wptr_q[AW-1:0]] <= rx_push_word;
  end

  // Head is forced to zero when empty so stale storage never shows.
  assign {rx_frame_err, rx_parity_err, uart_DO} = rx_empty ? '0 : rx_mem[rx_rptr_q[AW-1:0]];
  assign read_valid = !rx_empty;
  assign rx_overrun = rx_overrun_q;

endmodule
